// File: rtl/swan256_core_sched.sv
// swan256_core_sched
//   Shares one serial SWAN256 engine pair (encrypt + decrypt core, muxed outside
//   this block) between two requester channels. Jobs arrive on two valid/ready
//   request ports. They are arbitrated round-robin and sequenced into the engine
//   with a one-cycle start pulse. The engine result is captured on core_ready and
//   returned on the response port of the channel that issued the job.
//
// Optional feature (compile-time macro SWAN256_SCHED_WDOG_EN):
//   When defined, a RUN-cycle watchdog aborts a job after WDOG_CYCLES cycles
//   without core_ready. The job then responds with rsp_err = 1 and rsp_data = 0.
//   When undefined, RUN waits indefinitely and rsp_err is tied to 0.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready           channel N job handshake (ready only in the accept cycle)
//   reqN_dec/key/data          channel N mode (1 = decrypt), key, input block
//   rspN_valid/ready           channel N result handshake
//   rsp_data, rsp_err          captured result / abort flag, shared by both channels
//   core_start                 one-cycle engine load pulse
//   core_dec/key/inp           engine mode, key and input block (held from LOAD to RUN)
//   core_ready, core_out       engine done strobe and result
//   busy                       scheduler is not idle
module swan256_core_sched #(
    parameter int unsigned BLOCK_SIZE  = 256,
    parameter int unsigned KEY_SIZE    = 256,
    parameter int unsigned WDOG_CYCLES = 4095,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_dec,
    input  logic [KEY_SIZE-1:0]   req0_key,
    input  logic [BLOCK_SIZE-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_dec,
    input  logic [KEY_SIZE-1:0]   req1_key,
    input  logic [BLOCK_SIZE-1:0] req1_data,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [BLOCK_SIZE-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic                  core_dec,
    output logic [KEY_SIZE-1:0]   core_key,
    output logic [BLOCK_SIZE-1:0] core_inp,
    input  logic                  core_ready,
    input  logic [BLOCK_SIZE-1:0] core_out,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  job_dec_q, job_dec_d;
    logic [KEY_SIZE-1:0]   job_key_q, job_key_d;
    logic [BLOCK_SIZE-1:0] job_data_q, job_data_d;
    logic [BLOCK_SIZE-1:0] rsp_data_q, rsp_data_d;

    logic grant1;       // channel 1 wins arbitration if IDLE this cycle
    logic accept;       // a job is taken this cycle
    logic wdog_expire;  // last permitted RUN cycle without core_ready

    // Channel 1 wins when it is alone, or on a tie when channel 0 was served last.
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept = req0_ready | req1_ready;

`ifdef SWAN256_SCHED_WDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;

    // The counter holds the number of RUN cycles already spent. Expiring when it
    // reads WDOG_CYCLES-1 leaves RUN after exactly WDOG_CYCLES cycles.
    assign wdog_expire = (state_q == StRun) && (cnt_q == CNT_W'(WDOG_CYCLES - 1));

    always_comb begin
        cnt_d     = '0;
        rsp_err_d = rsp_err_q;
        if (state_q == StRun) begin
            cnt_d = cnt_q + 1'b1;
            // core_ready takes priority over a simultaneous expiry
            if (core_ready) begin
                rsp_err_d = 1'b0;
            end else if (wdog_expire) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign wdog_expire = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req0_valid | req1_valid) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (core_ready | wdog_expire) state_d = StResp;
            StResp:  if (last_grant_q ? rsp1_ready : rsp0_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        core_start = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low during reset so every output reads 0 while rst is high.
                if (!rst) begin
                    req1_ready = grant1;
                    req0_ready = req0_valid & ~grant1;
                end
            end
            StLoad: core_start = 1'b1;
            StRun:  ;
            StResp: begin
                rsp0_valid = ~last_grant_q;
                rsp1_valid = last_grant_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);

    // Job and result registers
    always_comb begin
        last_grant_d = last_grant_q;
        job_dec_d    = job_dec_q;
        job_key_d    = job_key_q;
        job_data_d   = job_data_q;
        rsp_data_d   = rsp_data_q;
        if (accept) begin
            // last_grant doubles as the grant of the job in flight
            last_grant_d = grant1;
            job_dec_d    = grant1 ? req1_dec  : req0_dec;
            job_key_d    = grant1 ? req1_key  : req0_key;
            job_data_d   = grant1 ? req1_data : req0_data;
        end
        // core_ready outside RUN is a stale strobe and never captured
        if (state_q == StRun) begin
            if (core_ready) begin
                rsp_data_d = core_out;
            end else if (wdog_expire) begin
                rsp_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            job_dec_q    <= 1'b0;
            job_key_q    <= '0;
            job_data_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            job_dec_q    <= job_dec_d;
            job_key_q    <= job_key_d;
            job_data_q   <= job_data_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign core_dec = job_dec_q;
    assign core_key = job_key_q;
    assign core_inp = job_data_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: doc/swan256_core_sched.md
Name: swan256_core_sched

Overview:
- Scheduler that shares one serial SWAN256 engine pair between two requester channels.
- The engine pair is an encrypt core and a decrypt core with common start/ready/out muxing outside this block.
- Accepts 256-bit key/data jobs on two valid/ready request ports and arbitrates round-robin.
- Sequences the engine with a one-cycle start pulse, captures the result on core ready, and returns it on the matching response port.

Parameters:
- BLOCK_SIZE, 256, data/result width in bits.
- KEY_SIZE, 256, key width in bits.
- WDOG_CYCLES, 4095, maximum RUN cycles before abort (used only with the optional feature).
- CNT_W, 16, width of the RUN cycle counter; must satisfy 2^CNT_W > WDOG_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  channel 0 job valid.
- req0_ready  out  1  channel 0 job accepted this cycle.
- req0_dec  in  1  channel 0 mode: 0 = encrypt, 1 = decrypt.
- req0_key  in  KEY_SIZE  channel 0 key.
- req0_data  in  BLOCK_SIZE  channel 0 input block.
- req1_valid, req1_ready, req1_dec, req1_key, req1_data: same as channel 0, for channel 1.
- rsp0_valid  out  1  result pending for channel 0.
- rsp0_ready  in  1  channel 0 takes result.
- rsp1_valid  out  1  result pending for channel 1.
- rsp1_ready  in  1  channel 1 takes result.
- rsp_data  out  BLOCK_SIZE  captured result, shared by both response ports.
- rsp_err  out  1  result is an abort, qualified by rspX_valid.
- core_start  out  1  engine load pulse.
- core_dec  out  1  engine mode select.
- core_key  out  KEY_SIZE  engine key.
- core_inp  out  BLOCK_SIZE  engine input block.
- core_ready  in  1  engine done; core_out valid this cycle.
- core_out  in  BLOCK_SIZE  engine result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so channel 0 wins the first tie; job registers 0; counter 0.
- FSM states and transitions:
  - IDLE -> LOAD when any reqX_valid is high.
  - LOAD -> RUN unconditionally (1 cycle).
  - RUN -> RESP on core_ready, or on watchdog expiry.
  - RESP -> IDLE when the granted rspX_ready is high.
- IDLE arbitration:
  - Only one valid: grant that channel.
  - Both valid: grant the channel != last_grant.
  - reqX_ready pulses high for exactly the acceptance cycle, combinationally from state and valid.
  - On acceptance: dec/key/data are registered, grant and last_grant are updated.
  - The non-granted channel sees ready = 0 and must hold its request.
- LOAD:
  - core_start = 1 for exactly one cycle.
  - core_dec/core_key/core_inp are driven from the job registers; they are stable from LOAD through RUN.
- RUN:
  - core_start = 0; the counter increments each cycle.
  - On core_ready: rsp_data <= core_out, rsp_err <= 0.
  - core_ready seen in IDLE, LOAD or RESP is ignored, with no capture.
  - core_ready in the same cycle as watchdog expiry: core_ready wins and the result is captured normally.
- RESP:
  - Only the granted rspX_valid is high; it holds with rsp_data/rsp_err stable until its rspX_ready.
  - The other channel's rspX_ready is ignored.
  - No new job is accepted until back in IDLE, so turnaround to the next acceptance is at least 1 IDLE cycle.
- Latency: acceptance -> rsp valid = 2 + N cycles, where N = RUN cycles until core_ready.
- rst mid-operation:
  - Immediate return to IDLE with all outputs 0; the pending job and result are discarded.
  - last_grant returns to 1.
  - The engine is re-synchronised by the next core_start.
- busy = (state != IDLE).

Optional Feature:
- Macro: SWAN256_SCHED_WDOG_EN.
- Defined:
  - In RUN, when the counter reaches WDOG_CYCLES without core_ready, go to RESP with rsp_err = 1 and rsp_data = 0.
  - A core_ready arriving later is ignored.
- Undefined:
  - No watchdog; RUN waits indefinitely.
  - rsp_err is tied to 0.
  - The counter may be omitted.

Test Plan:
- Single job, ch0: key = 0, data = 0x7856341278563412 repeated 4x, dec = 0.
  - Required: core_start is high exactly 1 cycle after acceptance.
  - Required: rsp0_valid with rsp_data = 0x7bfc52c91831bb1925dfeb802f78e65949fca8b47b830fcb46b3b57620e3775c and rsp_err = 0.
- Round trip on ch1: key = all 1s, data = 0x5e7f7837ab855ba2666046be47c2b93a435db79615506e3128b7fd3d1a0f22c2, dec = 1.
  - Required: rsp1 data = 0xf0debc9a78563412 repeated 4x; rsp0_valid stays 0.
- Contention: req0 and req1 valid in the same cycle after reset.
  - Required: ch0 is granted first and ch1 next.
  - Then both again -> ch0 and ch1 alternate for 4 jobs; per-channel results match the vectors.
- Backpressure: hold rsp0_ready = 0 for 20 cycles.
  - Required: rsp0_valid and rsp_data stay stable; req1_ready stays 0 throughout; ch1 is accepted 1 cycle after the IDLE return.
- Reset in RUN: assert rst for 1 cycle midway through RUN.
  - Required: all outputs are 0 on the next edge and no response is issued.
  - A new ch1 job completes correctly.
- With SWAN256_SCHED_WDOG_EN, WDOG_CYCLES = 50, core_ready tied 0.
  - Required: rsp0_valid after 52 cycles with rsp_err = 1 and rsp_data = 0.
